cpu_tick_stats_unit: RTL and testbench
======================================

# cpu_tick_stats_unit

Clocking, statistics and display block for the pipelined CPU top. It divides `fast_clk` into a CPU tick, which can free-run, single-step or pause. It also runs `NUM_CNT` generic saturating event counters that freeze on halt, and drives a multi-digit 7-segment display with a run-time selected counter. It replaces the fixed divider, fixed four-counter and fixed display-select logic at the CPU top with one parametrised unit.

## Interface
Parameters:
- `NUM_CNT`, default 4: number of event counters (1..16).
- `CNT_W`, default 32: counter width; display shows the low `4*DIGITS` bits.
- `CPU_DIV`, default 500000: `fast_clk` cycles per free-run CPU tick (≥2).
- `SCAN_DIV`, default 50000: `fast_clk` cycles per display digit (≥1).
- `DIGITS`, default 8: number of hex digits scanned.

Ports:
- `fast_clk` in, 1: system clock.
- `reset` in, 1: reset, asynchronous, active-high; clock `fast_clk`.
- `run_mode` in, 2: 00 free-run, 01 single-step, 10/11 pause.
- `step_btn` in, 1: asynchronous step request (level).
- `clr` in, 1: synchronous clear of counters and freeze flag.
- `halt` in, 1: CPU halt indication, sampled on ticks.
- `cnt_inc` in, `NUM_CNT`: per-counter increment request, sampled on ticks.
- `sel` in, 4: counter shown on the display.
- `cpu_tick` out, 1: one-`fast_clk` pulse per CPU step (used as clock enable).
- `frozen` out, 1: halt latched.
- `seg_out` out, 7: active-low segments {g,f,e,d,c,b,a}.
- `seg_an` out, `DIGITS`: active-low one-hot digit enable.
- `dp` out, 1: active-low decimal point.

## Operation
- Divider: `div_cnt` runs 0..`CPU_DIV`-1 in free-run mode. `cpu_tick`=1 for the cycle in which `div_cnt`==`CPU_DIV`-1, and `div_cnt` wraps to 0 on that cycle.
  - Any change of `run_mode` clears `div_cnt` to 0 on the next edge.
  - In modes other than free-run, `div_cnt` holds at 0.
- Single-step: `step_btn` passes through a 2-FF synchroniser, then a rising-edge detector. Each detected edge gives exactly one `cpu_tick`, one cycle after detection. Edges arriving in other modes are discarded.
- Pause: `cpu_tick` stays 0.
- Counters: on a `cpu_tick` cycle with `frozen`=0, counter i increments if `cnt_inc[i]`=1. A counter saturates at all-ones and never wraps.
- Freeze: on a `cpu_tick` cycle with `halt`=1, `frozen` sets on that edge. The counter update on that same tick still occurs. `frozen` stays set until `clr` or `reset`. `cpu_tick` keeps running while frozen.
- Clear: `clr`=1 zeroes all counters and `frozen`. `clr` has priority over a simultaneous tick increment.
- Display value: `disp_val` is registered each cycle from counter[`sel`], or 0 if `sel`≥`NUM_CNT`. It is zero-extended or truncated to `4*DIGITS` bits.
- Scan:
  - `scan_cnt` runs 0..`SCAN_DIV`-1. At wrap, `dig_idx` advances and wraps from `DIGITS`-1 to 0.
  - `seg_an` = ~(1<<`dig_idx`).
  - `seg_out` = hex pattern of nibble `dig_idx` of `disp_val`, registered.
- Hex patterns: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
- `dp`=0 only when `frozen`=1 and `dig_idx`==0; otherwise 1.

## Timing
- Reset values: `cpu_tick`=0, `frozen`=0, all counters 0, `div_cnt`/`scan_cnt`/`dig_idx`=0, `disp_val`=0, `seg_an`=~1, `seg_out`=1000000, `dp`=1, synchroniser and edge-detect flops 0.
- Free-run: the first `cpu_tick` is high in cycle `CPU_DIV` after `reset` deasserts (cycles numbered from 1), then every `CPU_DIV` cycles.
- Counter value is visible the cycle after the tick. `disp_val` adds 1 cycle, and `seg_out` adds 1 more cycle.
- Step latency: `step_btn` rise to `cpu_tick` is 3–4 `fast_clk` cycles (2 sync, 1 edge, 1 tick register).
- Reset asserted mid-operation forces all reset values immediately, independent of the clock.

## Test plan
- Free-run (`CPU_DIV`=4): release reset → `cpu_tick` high at cycles 4, 8, 12; `run_mode` toggled 00→10→00 → next tick comes 4 cycles after the return to 00.
- Counting (`cnt_inc`=0001, `sel`=0, 10 ticks) → counter0=10, counter1..3=0; with `dig_idx`=0, `seg_out`=0001000 ('A'); `sel`=5 → `seg_out`=1000000.
- Saturation (`CNT_W`=4, `cnt_inc`=1 for 20 ticks) → counter holds 15; the display shows 'F' on digit 0 and '0' on the other digits.
- Halt: `halt`=1 on the 5th tick with `cnt_inc`=1 → counter=5, `frozen`=1, later ticks leave it at 5, `dp`=0 only while digit 0 is active; `clr` pulse → counter=0, `frozen`=0.
- Single-step: `run_mode`=01, three `step_btn` pulses 10 cycles apart → exactly 3 `cpu_tick` pulses; `run_mode`=10 plus a pulse → none.
- Scan and reset (`SCAN_DIV`=2, `DIGITS`=8): `seg_an` steps FE, FD, …, 7F, FE every 2 cycles; async `reset` mid-count → outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/cpu_tick_stats_unit.sv
// CPU tick generator (free-run / single-step / pause), saturating event counters
// with halt freeze, and a scanned multi-digit 7-segment display of one counter.
module cpu_tick_stats_unit #(
   parameter int NUM_CNT  = 4,
   parameter int CNT_W    = 32,
   parameter int CPU_DIV  = 500000,
   parameter int SCAN_DIV = 50000,
   parameter int DIGITS   = 8
) (
   input  logic               fast_clk,
   input  logic               reset,
   input  logic [1:0]         run_mode,
   input  logic               step_btn,
   input  logic               clr,
   input  logic               halt,
   input  logic [NUM_CNT-1:0] cnt_inc,
   input  logic [3:0]         sel,
   output logic               cpu_tick,
   output logic               frozen,
   output logic [6:0]         seg_out,
   output logic [DIGITS-1:0]  seg_an,
   output logic               dp
);

   localparam int DIV_W  = $clog2(CPU_DIV);
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DISP_W = 4 * DIGITS;

   typedef enum logic [1:0] {
      MODE_RUN    = 2'b00,
      MODE_STEP   = 2'b01,
      MODE_PAUSE  = 2'b10,
      MODE_PAUSE2 = 2'b11
   } mode_e;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      unique case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   mode_e              mode;
   logic [1:0]         mode_q;
   logic [DIV_W-1:0]   div_cnt;
   logic               div_last;
   logic               sync1, sync2, step_prev, step_tick;
   logic [CNT_W-1:0]   cnt [NUM_CNT];
   logic [DISP_W-1:0]  disp_val, disp_next;
   logic [SCAN_W-1:0]  scan_cnt;
   logic [DIG_W-1:0]   dig_idx;
   logic [3:0]         nibble;

   assign mode     = mode_e'(run_mode);
   assign div_last = (div_cnt == DIV_W'(CPU_DIV - 1));
   assign cpu_tick = step_tick | ((mode == MODE_RUN) && div_last);

   // A mode change restarts the free-run period from zero.
   always_ff @(posedge fast_clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         mode_q  <= 2'b00;
      end else begin
         mode_q <= run_mode;
         if (run_mode != mode_q || mode != MODE_RUN || div_last)
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge fast_clk or posedge reset) begin
      if (reset) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         step_prev <= 1'b0;
         step_tick <= 1'b0;
      end else begin
         sync1     <= step_btn;
         sync2     <= sync1;
         step_prev <= sync2;
         step_tick <= sync2 && !step_prev && (mode == MODE_STEP);
      end
   end

   // NOTE: the counter array is real state, so every element is reset explicitly.
   always_ff @(posedge fast_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
         frozen <= 1'b0;
      end else if (clr) begin
         for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
         frozen <= 1'b0;
      end else if (cpu_tick) begin
         if (!frozen) begin
            for (int i = 0; i < NUM_CNT; i++)
               if (cnt_inc[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
         end
         if (halt) frozen <= 1'b1;
      end
   end

   // NOTE: default assigned first so no path through the loop can infer a latch.
   always_comb begin
      disp_next = '0;
      for (int i = 0; i < NUM_CNT; i++)
         if (sel == 4'(i)) disp_next = DISP_W'(cnt[i]);
   end

   assign nibble = 4'(disp_val >> {dig_idx, 2'b00});
   assign seg_an = ~(DIGITS'(1) << dig_idx);
   assign dp     = ~(frozen && dig_idx == '0);

   always_ff @(posedge fast_clk or posedge reset) begin
      if (reset) begin
         disp_val <= '0;
         scan_cnt <= '0;
         dig_idx  <= '0;
         seg_out  <= 7'b1000000;
      end else begin
         disp_val <= disp_next;
         seg_out  <= hex7(nibble);
         if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            dig_idx  <= (dig_idx == DIG_W'(DIGITS - 1)) ? '0 : dig_idx + DIG_W'(1);
         end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cpu_tick_stats_unit.sv
// Scoreboard bench: stimulus queues expected tick windows and display snapshots,
// independent monitors compare them against what the unit actually produces.
module tb_cpu_tick_stats_unit;

   localparam int NUM_CNT  = 4;
   localparam int CNT_W    = 4;
   localparam int CPU_DIV  = 4;
   localparam int SCAN_DIV = 2;
   localparam int DIGITS   = 8;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic               fast_clk = 1'b0;
   logic               reset    = 1'b1;
   logic [1:0]         run_mode = 2'b00;
   logic               step_btn = 1'b0;
   logic               clr      = 1'b0;
   logic               halt     = 1'b0;
   logic [NUM_CNT-1:0] cnt_inc  = '0;
   logic [3:0]         sel      = '0;
   logic               cpu_tick, frozen, dp;
   logic [6:0]         seg_out;
   logic [DIGITS-1:0]  seg_an;

   cpu_tick_stats_unit #(
      .NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .CPU_DIV(CPU_DIV),
      .SCAN_DIV(SCAN_DIV), .DIGITS(DIGITS)
   ) dut (
      .fast_clk(fast_clk), .reset(reset), .run_mode(run_mode), .step_btn(step_btn),
      .clr(clr), .halt(halt), .cnt_inc(cnt_inc), .sel(sel), .cpu_tick(cpu_tick),
      .frozen(frozen), .seg_out(seg_out), .seg_an(seg_an), .dp(dp)
   );

   always #5 fast_clk = ~fast_clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc_no;

   always @(posedge fast_clk or posedge reset)
      if (reset) cyc_no <= 0;
      else       cyc_no <= cyc_no + 1;

   // Cycle numbering starts at 1 for the cycle in which reset is released.
   function automatic int cyc();
      return cyc_no + 1;
   endfunction

   typedef struct packed { int lo; int hi; } win_t;
   typedef struct packed { logic [3:0] sel; int val; logic frz; } disp_t;

   win_t  tick_q[$];
   disp_t disp_q[$];
   bit    disp_busy = 1'b0;

   int m_cnt [NUM_CNT];
   bit m_frozen;
   int next_free;

   function automatic logic [6:0] ref_hex(input int n);
      case (n)
         0: return 7'b1000000;   1: return 7'b1111001;
         2: return 7'b0100100;   3: return 7'b0110000;
         4: return 7'b0011001;   5: return 7'b0010010;
         6: return 7'b0000010;   7: return 7'b1111000;
         8: return 7'b0000000;   9: return 7'b0010000;
         10: return 7'b0001000; 11: return 7'b0000011;
         12: return 7'b1000110; 13: return 7'b0100001;
         14: return 7'b0000110; default: return 7'b0001110;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc());
      end
   endtask

   // Tick monitor: every cpu_tick pulse must match the oldest expected window.
   always @(negedge fast_clk) begin
      if (!reset && cpu_tick) begin
         n_vec++;
         if (tick_q.size() == 0) begin
            n_err++;
            $display("FAIL tick_unexpected: cpu_tick=1 at cycle %0d, none due", cyc());
         end else begin
            win_t w;
            w = tick_q.pop_front();
            if (cyc() < w.lo || cyc() > w.hi) begin
               n_err++;
               $display("FAIL tick_time: cpu_tick at cycle %0d, want %0d..%0d", cyc(), w.lo, w.hi);
            end
         end
      end
   end

   // Display monitor: one full scan sweep per request, against the scan model.
   initial begin
      forever begin
         @(negedge fast_clk);
         if (!reset && disp_q.size() > 0) begin
            disp_t r;
            int n, idx, pidx;
            disp_busy = 1'b1;
            r = disp_q.pop_front();
            repeat (3) @(negedge fast_clk);
            check($sformatf("frozen sel=%0d", r.sel), int'(frozen), int'(r.frz));
            for (int k = 0; k < 2 * SCAN_DIV * DIGITS; k++) begin
               @(negedge fast_clk);
               n    = cyc();
               idx  = ((n - 1) / SCAN_DIV) % DIGITS;
               pidx = ((n - 2) / SCAN_DIV) % DIGITS;
               check($sformatf("seg_an sel=%0d", r.sel), int'(seg_an),
                     (~(1 << idx)) & ((1 << DIGITS) - 1));
               check($sformatf("seg_out sel=%0d digit=%0d", r.sel, pidx), int'(seg_out),
                     int'(ref_hex((r.val >> (4 * pidx)) & 15)));
               check($sformatf("dp sel=%0d", r.sel), int'(dp), (r.frz && idx == 0) ? 0 : 1);
            end
            disp_busy = 1'b0;
         end
      end
   end

   task automatic step1();
      @(posedge fast_clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM_CNT; i++) m_cnt[i] = 0;
      m_frozen = 1'b0;
   endtask

   task automatic model_tick(input logic [NUM_CNT-1:0] inc, input logic h);
      if (!m_frozen)
         for (int i = 0; i < NUM_CNT; i++)
            if (inc[i] && m_cnt[i] < CNT_MAX) m_cnt[i]++;
      if (h) m_frozen = 1'b1;
   endtask

   task automatic set_mode(input logic [1:0] m);
      if (m == 2'b00 && run_mode != 2'b00) next_free = cyc() + CPU_DIV;
      run_mode = m;
   endtask

   task automatic run_tick(input logic [NUM_CNT-1:0] inc, input logic h);
      int t;
      cnt_inc = inc;
      halt    = h;
      t       = next_free;
      tick_q.push_back('{lo: t, hi: t});
      while (cyc() <= t) step1();
      model_tick(inc, h);
      next_free += CPU_DIV;
   endtask

   // Clear lands exactly on a free-run tick with every increment requested.
   task automatic run_tick_clr();
      int t;
      cnt_inc = '1;
      halt    = 1'b0;
      t       = next_free;
      tick_q.push_back('{lo: t, hi: t});
      while (cyc() < t) step1();
      clr = 1'b1;
      step1();
      clr     = 1'b0;
      cnt_inc = '0;
      model_clear();
      next_free += CPU_DIV;
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      step1();
      clr = 1'b0;
      model_clear();
   endtask

   task automatic step_pulse(input logic [NUM_CNT-1:0] inc, input logic h, input bit expect_tick);
      int s;
      cnt_inc  = inc;
      halt     = h;
      s        = cyc();
      step_btn = 1'b1;
      if (expect_tick) tick_q.push_back('{lo: s + 3, hi: s + 4});
      repeat (2) step1();
      step_btn = 1'b0;
      repeat (8) step1();
      if (expect_tick) model_tick(inc, h);
   endtask

   task automatic disp_check(input logic [3:0] s);
      disp_t r;
      bit done;
      sel   = s;
      r.sel = s;
      r.val = 0;
      if (int'(s) < NUM_CNT) r.val = m_cnt[s];
      r.frz = m_frozen;
      disp_q.push_back(r);
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         step1();
         if (disp_q.size() == 0 && !disp_busy) done = 1'b1;
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL disp_timeout: display check for sel=%0d never completed", s);
      end
   endtask

   task automatic reset_checks(input string tag);
      check({tag, " cpu_tick"}, int'(cpu_tick), 0);
      check({tag, " frozen"},   int'(frozen),   0);
      check({tag, " seg_out"},  int'(seg_out),  'h40);
      check({tag, " seg_an"},   int'(seg_an),   'hFE);
      check({tag, " dp"},       int'(dp),       1);
   endtask

   initial begin
      model_clear();
      repeat (3) step1();
      reset_checks("reset");
      @(posedge fast_clk);
      #1 reset = 1'b0;
      next_free = CPU_DIV;

      // Free-run: ticks at cycles 4, 8, 12; pause/resume restarts the period.
      repeat (3) run_tick('0, 1'b0);
      set_mode(2'b10);
      repeat (3) step1();
      set_mode(2'b00);
      run_tick('0, 1'b0);

      // Counting on counter 0 only.
      repeat (10) run_tick(4'b0001, 1'b0);
      set_mode(2'b10);
      for (int s = 0; s < NUM_CNT; s++) disp_check(4'(s));
      disp_check(4'd5);

      // Saturation.
      clr_pulse();
      set_mode(2'b00);
      repeat (20) run_tick(4'b0001, 1'b0);
      set_mode(2'b10);
      disp_check(4'd0);
      disp_check(4'd1);

      // Random increment patterns.
      set_mode(2'b00);
      repeat (24) run_tick(NUM_CNT'($urandom_range(0, 15)), 1'b0);
      set_mode(2'b10);
      for (int s = 0; s < NUM_CNT; s++) disp_check(4'(s));

      // Clear wins over a simultaneous tick.
      set_mode(2'b00);
      run_tick('1, 1'b0);
      run_tick_clr();
      set_mode(2'b10);
      for (int s = 0; s < NUM_CNT; s++) disp_check(4'(s));

      // Halt on the 5th tick freezes counters; ticks keep running.
      set_mode(2'b00);
      repeat (4) run_tick(4'b0001, 1'b0);
      run_tick(4'b0001, 1'b1);
      repeat (5) run_tick('1, 1'b0);
      set_mode(2'b10);
      disp_check(4'd0);
      disp_check(4'd1);
      clr_pulse();
      disp_check(4'd0);

      // Single-step: three pulses tick, a pulse while paused does not.
      set_mode(2'b01);
      repeat (3) step_pulse(NUM_CNT'($urandom_range(0, 15)), 1'b0, 1'b1);
      set_mode(2'b10);
      step_pulse('1, 1'b0, 1'b0);
      for (int s = 0; s < NUM_CNT; s++) disp_check(4'(s));

      // Random increments with occasional halts.
      clr_pulse();
      set_mode(2'b00);
      repeat (20) run_tick(NUM_CNT'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0));
      set_mode(2'b10);
      for (int s = 0; s < NUM_CNT; s++) disp_check(4'(s));

      // Asynchronous reset in the middle of a free-run period.
      set_mode(2'b00);
      repeat (3) run_tick('1, 1'b1);
      check("ticks_drained", tick_q.size(), 0);
      #2 reset = 1'b1;
      #1 reset_checks("async_reset");
      repeat (2) step1();
      reset = 1'b0;
      model_clear();
      next_free = CPU_DIV;
      cnt_inc   = '0;
      halt      = 1'b0;
      repeat (3) run_tick(4'b0001, 1'b0);
      set_mode(2'b10);
      disp_check(4'd0);

      repeat (10) step1();
      check("ticks_pending", tick_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
